// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stage and its input sequencer: state
// encoding and default widths.
package fir_pkg;

    localparam int FIR_X_N_SIZE    = 8;
    localparam int FIR_TAP_SIZE    = 6;
    localparam int FIR_NBR_OF_TAPS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LOAD   = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_input_sequencer_if.sv
// Host-side valid/ready word port. The host drives the word and its tag; the
// sequencer answers with in_ready.
interface fir_input_sequencer_if #(
    parameter int X_N_SIZE = fir_pkg::FIR_X_N_SIZE
);
    logic [X_N_SIZE-1:0] in_data;
    logic                in_is_coeff;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output in_data,
        output in_is_coeff,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_is_coeff,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fir_input_sequencer_sample_fifo.sv
// Small synchronous sample FIFO with a combinational head read, level count
// and full/empty flags. Push on full and pop on empty are ignored.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == DEPTH_C);
    assign empty   = (level_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (PTR_W + 1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/fir_input_sequencer.sv
// Feeds the FIR stage: tags host words as samples or coefficients, queues
// samples, stages one coefficient set, and presents either a sample stream or
// an atomic coefficient load on registered FIR-facing outputs.
module fir_input_sequencer
    import fir_pkg::*;
#(
    parameter int X_N_SIZE    = FIR_X_N_SIZE,
    parameter int TAP_SIZE    = FIR_TAP_SIZE,
    parameter int NBR_OF_TAPS = FIR_NBR_OF_TAPS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fir_input_sequencer_if.slave          host,
    output logic [X_N_SIZE-1:0]           x_n,
    output logic                          s_axis_fir_tvalid,
    output logic                          s_set_coeffs,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          coeff_loaded
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(NBR_OF_TAPS + 1);
    localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(NBR_OF_TAPS);

    fir_state_t state_reg, state_next;

    logic [CNT_W-1:0]    stage_cnt_reg;
    logic [CNT_W-1:0]    load_cnt_reg;
    logic [TAP_SIZE-1:0] stage_reg [NBR_OF_TAPS];

    logic [X_N_SIZE-1:0] x_n_reg, x_n_next;
    logic                tvalid_reg, tvalid_next;
    logic                set_reg, set_next;
    logic                loaded_reg, loaded_next;

    logic [X_N_SIZE-1:0] fifo_head;
    logic [LVL_W-1:0]    fifo_level_w;
    logic                fifo_full;
    logic                fifo_empty;

    logic                coeff_ready;
    logic                sample_ready;
    logic                coeff_accept;
    logic                push;
    logic                pop;
    logic                load_last;
    logic                stream_drains;
    logic [CNT_W-1:0]    coeff_idx;
    logic [TAP_SIZE-1:0] sel_coeff;
    logic [X_N_SIZE-1:0] coeff_ext;

    // Handshake: coefficients stall while a full set waits or loads; samples
    // stall only on a full FIFO (registered level, no push-through).
    assign coeff_ready   = (stage_cnt_reg < TAPS_C) && (state_reg != LOAD);
    assign sample_ready  = !fifo_full;
    assign host.in_ready = host.in_is_coeff ? coeff_ready : sample_ready;
    assign coeff_accept  = host.in_valid && host.in_is_coeff && coeff_ready;
    assign push          = host.in_valid && !host.in_is_coeff && sample_ready;
    assign pop           = (state_reg == STREAM) && !fifo_empty;

    // Streaming ends when this edge's pop leaves the FIFO empty and nothing refills it.
    assign stream_drains = (fifo_level_w <= LVL_W'(1)) && !push;
    assign load_last     = (load_cnt_reg == TAPS_C);

    // Load cycle 0 is a lead-in repeating stage[0]; cycle k presents stage[k-1].
    assign coeff_idx = (load_cnt_reg == '0) ? '0 : (load_cnt_reg - CNT_W'(1));

    sample_fifo #(
        .WIDTH (X_N_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (host.in_data),
        .rd_data (fifo_head),
        .level   (fifo_level_w),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Coefficient staging registers, one per tap, written in arrival order.
    generate
        for (genvar gi = 0; gi < NBR_OF_TAPS; gi++) begin : g_stage
            // Capture the accepted coefficient into the slot the count points at.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else if (coeff_accept && (stage_cnt_reg == CNT_W'(gi))) begin
                    stage_reg[gi] <= host.in_data[TAP_SIZE-1:0];
                end
            end
        end
    endgenerate

    // Staging count: cleared on the edge that finishes a load, so the next
    // set can only start once the current one has been handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_cnt_reg <= '0;
        end else if ((state_reg == LOAD) && load_last) begin
            stage_cnt_reg <= '0;
        end else if (coeff_accept) begin
            stage_cnt_reg <= stage_cnt_reg + CNT_W'(1);
        end
    end

    // Position within the load sequence; idle at zero outside LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_reg <= '0;
        end else if ((state_reg == LOAD) && !load_last) begin
            load_cnt_reg <= load_cnt_reg + CNT_W'(1);
        end else begin
            load_cnt_reg <= '0;
        end
    end

    // Select the staged coefficient for the current load position.
    always_comb begin
        sel_coeff = stage_reg[0];
        for (int i = 1; i < NBR_OF_TAPS; i++) begin
            if (coeff_idx == CNT_W'(i)) begin
                sel_coeff = stage_reg[i];
            end
        end
    end

    // Sign-extend the tap to the FIR input width.
    generate
        if (X_N_SIZE > TAP_SIZE) begin : g_sext
            assign coeff_ext = {{(X_N_SIZE - TAP_SIZE){sel_coeff[TAP_SIZE-1]}}, sel_coeff};
        end else begin : g_same
            assign coeff_ext = sel_coeff;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and next FIR-facing output values; a complete staged set
    // pre-empts streaming from any state.
    always_comb begin
        state_next  = state_reg;
        x_n_next    = '0;
        tvalid_next = 1'b0;
        set_next    = 1'b0;
        loaded_next = 1'b0;

        case (state_reg)
            STREAM: begin
                if (pop) begin
                    x_n_next    = fifo_head;
                    tvalid_next = 1'b1;
                end
            end
            LOAD: begin
                x_n_next    = coeff_ext;
                set_next    = 1'b1;
                loaded_next = load_last;
            end
            default: begin
            end
        endcase

        if ((state_reg != LOAD) && (stage_cnt_reg == TAPS_C)) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    if (stream_drains) begin
                        state_next = IDLE;
                    end
                end
                LOAD: begin
                    if (load_last) begin
                        state_next = fifo_empty ? IDLE : STREAM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered FIR-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_n_reg    <= '0;
            tvalid_reg <= 1'b0;
            set_reg    <= 1'b0;
            loaded_reg <= 1'b0;
        end else begin
            x_n_reg    <= x_n_next;
            tvalid_reg <= tvalid_next;
            set_reg    <= set_next;
            loaded_reg <= loaded_next;
        end
    end

    assign x_n               = x_n_reg;
    assign s_axis_fir_tvalid = tvalid_reg;
    assign s_set_coeffs      = set_reg;
    assign coeff_loaded      = loaded_reg;
    assign fifo_level        = fifo_level_w;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed bench for fir_input_sequencer with a queue-based reference model.
module tb_fir_input_sequencer;

    localparam int XW    = 8;
    localparam int TW    = 6;
    localparam int TAPS  = 3;
    localparam int DEPTH = 4;
    localparam int LOGN  = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] x_n;
    logic       tvalid;
    logic       set_c;
    logic       loaded;
    logic [2:0] level;

    fir_input_sequencer_if #(.X_N_SIZE(XW)) host_if ();

    fir_input_sequencer #(
        .X_N_SIZE    (XW),
        .TAP_SIZE    (TW),
        .NBR_OF_TAPS (TAPS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host              (host_if),
        .x_n               (x_n),
        .s_axis_fir_tvalid (tvalid),
        .s_set_coeffs      (set_c),
        .fifo_level        (level),
        .coeff_loaded      (loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: queues for the FIFO, staged set and load sequence.
    typedef enum int {M_IDLE, M_STREAM, M_LOAD} mmode_t;
    mmode_t     m_mode = M_IDLE;
    logic [7:0] m_fifo [$];
    logic [5:0] m_stage [$];
    logic [7:0] m_seq [$];
    logic [7:0] e_x   = '0;
    logic       e_tv  = 1'b0;
    logic       e_set = 1'b0;
    logic       e_ld  = 1'b0;

    // Scoreboard of samples sent/observed, and per-cycle output log.
    logic [7:0] sent [$];
    logic [7:0] seen [$];
    logic [7:0] log_x   [LOGN];
    logic       log_tv  [LOGN];
    logic       log_set [LOGN];
    logic       log_ld  [LOGN];

    function automatic logic [7:0] sext(input logic [5:0] c);
        return {{2{c[5]}}, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int old_size;
        bit c_rdy, s_rdy, acc_c, acc_s;
        old_size = m_fifo.size();
        c_rdy = (m_stage.size() < TAPS) && (m_mode != M_LOAD);
        s_rdy = old_size < DEPTH;
        acc_c = host_if.in_valid && host_if.in_is_coeff && c_rdy;
        acc_s = host_if.in_valid && !host_if.in_is_coeff && s_rdy;
        e_x = '0; e_tv = 1'b0; e_set = 1'b0; e_ld = 1'b0;
        if (m_mode == M_STREAM && old_size > 0) begin
            e_x = m_fifo.pop_front();
            e_tv = 1'b1;
        end else if (m_mode == M_LOAD) begin
            e_set = 1'b1;
            e_x = m_seq.pop_front();
            e_ld = (m_seq.size() == 0);
        end
        if (m_mode != M_LOAD && m_stage.size() == TAPS) begin
            m_mode = M_LOAD;
            m_seq.delete();
            m_seq.push_back(sext(m_stage[0]));
            foreach (m_stage[i]) m_seq.push_back(sext(m_stage[i]));
        end else if (m_mode == M_LOAD) begin
            if (m_seq.size() == 0) begin
                m_stage.delete();
                m_mode = (old_size > 0) ? M_STREAM : M_IDLE;
            end
        end else if (m_mode == M_IDLE) begin
            if (old_size > 0) m_mode = M_STREAM;
        end else begin
            if (m_fifo.size() == 0 && !acc_s) m_mode = M_IDLE;
        end
        if (acc_s) m_fifo.push_back(host_if.in_data);
        if (acc_c) m_stage.push_back(host_if.in_data[5:0]);
    endtask

    always @(posedge clk) cyc++;

    // Model advances on each edge; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete(); m_stage.delete(); m_seq.delete();
            m_mode = M_IDLE;
            e_x = '0; e_tv = 1'b0; e_set = 1'b0; e_ld = 1'b0;
        end else begin
            model_step();
        end
    end

    // Compare every cycle mid-period.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = host_if.in_is_coeff ? ((m_stage.size() < TAPS) && (m_mode != M_LOAD))
                                      : (m_fifo.size() < DEPTH);
        check("x_n", 32'(x_n), 32'(e_x));
        check("tvalid", 32'(tvalid), 32'(e_tv));
        check("set_coeffs", 32'(set_c), 32'(e_set));
        check("coeff_loaded", 32'(loaded), 32'(e_ld));
        check("fifo_level", 32'(level), 32'(m_fifo.size()));
        check("in_ready", 32'(host_if.in_ready), 32'(exp_rdy));
        check("set_tvalid_excl", 32'(set_c & tvalid), 32'd0);
        if (cyc < LOGN) begin
            log_x[cyc] = x_n; log_tv[cyc] = tvalid;
            log_set[cyc] = set_c; log_ld[cyc] = loaded;
        end
        if (tvalid) seen.push_back(x_n);
    end

    // Present one word and hold it until accepted; returns the accepting edge.
    task automatic drive_word(input logic [7:0] d, input logic c, input int max_wait, output int acc_cyc);
        int  w;
        bit  done;
        bit  rdy;
        w = 0; done = 0; acc_cyc = -1;
        host_if.in_data = d; host_if.in_is_coeff = c; host_if.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = host_if.in_ready;
            @(posedge clk);
            #1;
            w++;
            if (rdy) begin
                done = 1;
                acc_cyc = cyc;
                if (!c) sent.push_back(d);
                $display("%s 0x%02h accepted at cycle %0d", c ? "coeff " : "sample", d, cyc);
            end else if (w >= max_wait) begin
                done = 1;
                checks++; errors++;
                $display("FAIL accept_timeout: word 0x%02h not accepted within %0d cycles", d, max_wait);
            end
        end
        host_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, 32'(seen.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
            check({name, "_data"}, 32'(seen[i]), 32'(sent[i]));
        end
        $display("%s: %0d samples sent, %0d observed", name, sent.size(), seen.size());
        sent.delete(); seen.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a, b, e0, cnt;
        host_if.in_valid = 1'b0; host_if.in_is_coeff = 1'b0; host_if.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state.
        check("rst_x_n", 32'(x_n), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_set", 32'(set_c), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(host_if.in_ready), 32'd1);
        rst = 1'b0;

        // T2: back-to-back samples from reset.
        drive_word(8'd5, 1'b0, 10, k);
        drive_word(8'hFD, 1'b0, 10, a);
        drive_word(8'd12, 1'b0, 10, b);
        check("t2_b2b", 32'(b), 32'(k + 2));
        idle(8);
        check("t2_x0", 32'(log_x[k+2]), 32'h05);
        check("t2_v0", 32'(log_tv[k+2]), 32'd1);
        check("t2_x1", 32'(log_x[k+3]), 32'hFD);
        check("t2_x2", 32'(log_x[k+4]), 32'h0C);
        check("t2_v2", 32'(log_tv[k+4]), 32'd1);
        check("t2_vend", 32'(log_tv[k+5]), 32'd0);
        check("t2_vpre", 32'(log_tv[k+1]), 32'd0);
        check_stream("t2_order");

        // T3: coefficient load 01, 3F, 02.
        drive_word(8'h01, 1'b1, 10, e0);
        drive_word(8'h3F, 1'b1, 10, a);
        drive_word(8'h02, 1'b1, 10, a);
        idle(10);
        check("t3_set_pre", 32'(log_set[e0+3]), 32'd0);
        check("t3_c0", 32'(log_x[e0+4]), 32'h01);
        check("t3_c1", 32'(log_x[e0+5]), 32'h01);
        check("t3_c2", 32'(log_x[e0+6]), 32'hFF);
        check("t3_c3", 32'(log_x[e0+7]), 32'h02);
        cnt = 0;
        for (int i = e0; i <= e0 + 10; i++) cnt += (log_set[i] ? 1 : 0);
        check("t3_set_len", 32'(cnt), 32'd4);
        cnt = 0;
        for (int i = e0; i <= e0 + 10; i++) cnt += (log_ld[i] ? 1 : 0);
        check("t3_loaded_once", 32'(cnt), 32'd1);
        check("t3_loaded_at", 32'(log_ld[e0+7]), 32'd1);

        // T4: coefficients arrive in the middle of an 8-sample stream.
        e0 = cyc;
        for (int i = 0; i < 3; i++) drive_word(8'(20 + i), 1'b0, 20, a);
        drive_word(8'h0A, 1'b1, 20, a);
        drive_word(8'h15, 1'b1, 20, a);
        drive_word(8'h30, 1'b1, 20, a);
        for (int i = 3; i < 8; i++) drive_word(8'(8'hF0 + i), 1'b0, 20, a);
        idle(15);
        cnt = 0;
        for (int i = e0; i < cyc; i++) cnt += (log_set[i] ? 1 : 0);
        check("t4_set_len", 32'(cnt), 32'd4);
        check_stream("t4_order");

        // T5: fill the FIFO while LOAD holds the stream.
        drive_word(8'h01, 1'b1, 10, e0);
        drive_word(8'h02, 1'b1, 10, a);
        drive_word(8'h03, 1'b1, 10, a);
        for (int i = 0; i < 4; i++) drive_word(8'(8'h40 + i), 1'b0, 20, a);
        check("t5_4th_at", 32'(a), 32'(e0 + 6));
        check("t5_level", 32'(level), 32'd4);
        check("t5_ready", 32'(host_if.in_ready), 32'd0);
        drive_word(8'h44, 1'b0, 20, a);
        drive_word(8'h45, 1'b0, 20, b);
        idle(12);
        check_stream("t5_order");

        // T6: a fourth coefficient stalls through LOAD and starts the next set.
        drive_word(8'h05, 1'b1, 10, e0);
        drive_word(8'h06, 1'b1, 10, a);
        drive_word(8'h07, 1'b1, 10, a);
        drive_word(8'h20, 1'b1, 20, a);
        check("t6_stall_until", 32'(a), 32'(e0 + 8));
        drive_word(8'h21, 1'b1, 10, b);
        drive_word(8'h22, 1'b1, 10, b);
        idle(10);
        check("t6_n0", 32'(log_x[e0+12]), 32'hE0);
        check("t6_n1", 32'(log_x[e0+13]), 32'hE0);
        check("t6_n2", 32'(log_x[e0+14]), 32'hE1);
        check("t6_n3", 32'(log_x[e0+15]), 32'hE2);

        // T1: reset in the middle of streaming.
        drive_word(8'h11, 1'b0, 10, a);
        drive_word(8'h12, 1'b0, 10, a);
        drive_word(8'h13, 1'b0, 10, a);
        check("t1_streaming", 32'(tvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_x_n", 32'(x_n), 32'd0);
        check("t1_tvalid", 32'(tvalid), 32'd0);
        check("t1_set", 32'(set_c), 32'd0);
        check("t1_loaded", 32'(loaded), 32'd0);
        check("t1_level", 32'(level), 32'd0);
        check("t1_ready", 32'(host_if.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        sent.delete(); seen.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
